// File: rtl/riscv_bp_ctrl.sv
// riscv_bp_ctrl: write-port sequencer for the branch-prediction pattern table.
// Sweeps the table to INIT_VALUE after reset and on flush, and merges
// branch-unit updates. Updates that arrive mid-sweep wait in a small FIFO
// and retire in arrival order.
// Optional macro RISCV_BP_CTRL_DROP_STATS_EN builds the saturating drop counter.
module riscv_bp_ctrl #(
    parameter int         BP_GLOBAL_BITS = 2,
    parameter int         BP_LOCAL_BITS  = 10,
    parameter logic [1:0] INIT_VALUE     = 2'b01,
    parameter int         FIFO_DEPTH     = 2,
    localparam int        ADR_BITS       = BP_GLOBAL_BITS + BP_LOCAL_BITS,
    localparam int        DEPTH          = 1 << ADR_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                bu_update_i,
    input  logic [ADR_BITS-1:0] bu_waddr_i,
    input  logic [1:0]          bu_wdata_i,
    output logic [ADR_BITS-1:0] ram_waddr_o,
    output logic [1:0]          ram_din_o,
    output logic                ram_we_o,
    output logic                busy_o,
    output logic                drop_o,
    output logic [15:0]         drop_cnt_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic {CLEAR, IDLE} state_t;

    typedef struct packed {
        logic [ADR_BITS-1:0] addr;
        logic [1:0]          data;
    } upd_t;

    state_t              state, state_n;
    logic [ADR_BITS-1:0] cnt, cnt_n;
    logic                we_n, drop_n;
    logic [ADR_BITS-1:0] waddr_n;
    logic [1:0]          din_n;

    upd_t                mem [FIFO_DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic                push, pop, fifo_clr, full, empty;
    upd_t                head, in_upd;

    assign full   = (count == CW'(FIFO_DEPTH));
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];
    assign in_upd = '{addr: bu_waddr_i, data: bu_wdata_i};
    assign busy_o = (state == CLEAR);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // State, sweep counter and registered write-port outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= CLEAR;
            cnt         <= '0;
            ram_we_o    <= 1'b0;
            ram_waddr_o <= '0;
            ram_din_o   <= INIT_VALUE;
            drop_o      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ram_we_o    <= we_n;
            ram_waddr_o <= waddr_n;
            ram_din_o   <= din_n;
            drop_o      <= drop_n;
        end
    end

    // Select this edge's write; a flush takes precedence over everything
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        we_n     = 1'b0;
        waddr_n  = ram_waddr_o;
        din_n    = ram_din_o;
        drop_n   = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        fifo_clr = 1'b0;
        case (state)
            CLEAR: begin
                // Updates postdate any flush, so they queue even on a flush edge
                if (bu_update_i) begin
                    if (full) drop_n = 1'b1;
                    else      push   = 1'b1;
                end
                if (flush_i) begin
                    cnt_n = '0;
                end else begin
                    we_n    = 1'b1;
                    waddr_n = cnt;
                    din_n   = INIT_VALUE;
                    cnt_n   = cnt + 1'b1;
                    if (cnt == ADR_BITS'(DEPTH - 1)) state_n = IDLE;
                end
            end
            IDLE: begin
                if (flush_i) begin
                    // Queued updates are stale once the table is re-initialised
                    fifo_clr = 1'b1;
                    cnt_n    = '0;
                    state_n  = CLEAR;
                end else if (!empty) begin
                    we_n    = 1'b1;
                    waddr_n = head.addr;
                    din_n   = head.data;
                    pop     = 1'b1;
                    push    = bu_update_i;
                end else if (bu_update_i) begin
                    we_n    = 1'b1;
                    waddr_n = bu_waddr_i;
                    din_n   = bu_wdata_i;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fifo_clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= in_upd;
    end

`ifdef RISCV_BP_CTRL_DROP_STATS_EN
    logic [15:0] drop_cnt;

    // Saturating count of discarded updates, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                             drop_cnt <= '0;
        else if (drop_n && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end

    assign drop_cnt_o = drop_cnt;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_riscv_bp_ctrl.sv
// Directed testbench for riscv_bp_ctrl (default parameters, 4096-entry table).
module tb_riscv_bp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        upd = 1'b0;
    logic [11:0] uaddr = '0;
    logic [1:0]  udata = '0;
    logic [11:0] waddr;
    logic [1:0]  din;
    logic        we, busy, drop;
    logic [15:0] drop_cnt;

    int npass = 0;
    int ntotal = 0;
    int n, bad;

`ifdef RISCV_BP_CTRL_DROP_STATS_EN
    localparam logic [15:0] DROP1 = 16'd1;
`else
    localparam logic [15:0] DROP1 = 16'd0;
`endif

    riscv_bp_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .bu_update_i(upd), .bu_waddr_i(uaddr), .bu_wdata_i(udata),
        .ram_waddr_o(waddr), .ram_din_o(din), .ram_we_o(we),
        .busy_o(busy), .drop_o(drop), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Tick until busy falls; every cycle must write INIT to the next ascending address
    task automatic sweep(input int start, output int nw, output int nbad);
        int exp_a;
        exp_a = start;
        nw = 0;
        nbad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (!(we === 1'b1 && waddr === exp_a[11:0] && din === 2'b01)) nbad++;
            exp_a++;
            nw++;
            if (busy === 1'b0) break;
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {20'd0, waddr}, 32'd0);
        chk("rst_din", {30'd0, din}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        chk("rst_dropcnt", {16'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;

        // Initial sweep
        sweep(0, n, bad);
        chk("init_sweep_len", n, 4096);
        chk("init_sweep_bad", bad, 0);
        tick();
        chk("init_idle_we", {31'd0, we}, 32'd0);
        chk("init_idle_busy", {31'd0, busy}, 32'd0);

        // Bypass write
        upd = 1'b1; uaddr = 12'h3A5; udata = 2'b11;
        tick();
        upd = 1'b0;
        chk("byp_we", {31'd0, we}, 32'd1);
        chk("byp_waddr", {20'd0, waddr}, 32'h3A5);
        chk("byp_din", {30'd0, din}, 32'd3);
        tick();
        chk("byp_we_off", {31'd0, we}, 32'd0);
        chk("byp_hold", {20'd0, waddr}, 32'h3A5);

        // Three updates during a sweep with a 2-entry FIFO
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_busy", {31'd0, busy}, 32'd1);
        upd = 1'b1; uaddr = 12'h111; udata = 2'b10;
        tick();
        chk("a_waddr", {20'd0, waddr}, 32'd0);
        chk("a_drop", {31'd0, drop}, 32'd0);
        uaddr = 12'h222; udata = 2'b11;
        tick();
        chk("b_waddr", {20'd0, waddr}, 32'd1);
        chk("b_drop", {31'd0, drop}, 32'd0);
        uaddr = 12'h333; udata = 2'b00;
        tick();
        upd = 1'b0;
        chk("c_waddr", {20'd0, waddr}, 32'd2);
        chk("c_drop", {31'd0, drop}, 32'd1);
        chk("c_dropcnt", {16'd0, drop_cnt}, {16'd0, DROP1});
        sweep(3, n, bad);
        chk("abc_sweep_len", n, 4093);
        chk("abc_sweep_bad", bad, 0);
        chk("abc_drop_once", {31'd0, drop}, 32'd0);
        tick();
        chk("a_we", {31'd0, we}, 32'd1);
        chk("a_addr", {20'd0, waddr}, 32'h111);
        chk("a_din", {30'd0, din}, 32'd2);
        tick();
        chk("b_we", {31'd0, we}, 32'd1);
        chk("b_addr", {20'd0, waddr}, 32'h222);
        chk("b_din", {30'd0, din}, 32'd3);
        tick();
        chk("c_never", {31'd0, we}, 32'd0);
        chk("abc_dropcnt", {16'd0, drop_cnt}, {16'd0, DROP1});

        // Flush mid-sweep at address 100
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        chk("pre100_waddr", {20'd0, waddr}, 32'd99);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sweep(0, n, bad);
        chk("refl_sweep_len", n, 4096);
        chk("refl_sweep_bad", bad, 0);

        // FIFO holding one entry plus a same-cycle update at sweep end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        upd = 1'b1; uaddr = 12'hABC; udata = 2'b10;
        tick();
        upd = 1'b0;
        sweep(1, n, bad);
        chk("d_sweep_len", n, 4095);
        chk("d_sweep_bad", bad, 0);
        upd = 1'b1; uaddr = 12'h5A5; udata = 2'b00;
        tick();
        upd = 1'b0;
        chk("d_head_addr", {20'd0, waddr}, 32'hABC);
        chk("d_head_din", {30'd0, din}, 32'd2);
        tick();
        chk("e_we", {31'd0, we}, 32'd1);
        chk("e_addr", {20'd0, waddr}, 32'h5A5);
        chk("e_din", {30'd0, din}, 32'd0);
        tick();
        chk("e_done", {31'd0, we}, 32'd0);

        // Flush in IDLE with two queued entries discards them
        flush = 1'b1;
        tick();
        flush = 1'b0;
        upd = 1'b1; uaddr = 12'h0F0; udata = 2'b11;
        tick();
        uaddr = 12'h0F1;
        tick();
        upd = 1'b0;
        sweep(2, n, bad);
        chk("fg_sweep_len", n, 4094);
        chk("fg_sweep_bad", bad, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fg_flush_we", {31'd0, we}, 32'd0);
        chk("fg_flush_busy", {31'd0, busy}, 32'd1);
        sweep(0, n, bad);
        chk("fg_resweep_len", n, 4096);
        chk("fg_resweep_bad", bad, 0);
        tick();
        chk("fg_never", {31'd0, we}, 32'd0);

        // Reset asserted mid-sweep at address 2000
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2000; i++) tick();
        chk("pre_rst_waddr", {20'd0, waddr}, 32'd1999);
        rst_n = 1'b0;
        #1;
        chk("mrst_we", {31'd0, we}, 32'd0);
        chk("mrst_waddr", {20'd0, waddr}, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd1);
        chk("mrst_dropcnt", {16'd0, drop_cnt}, 32'd0);
        #2;
        rst_n = 1'b1;
        sweep(0, n, bad);
        chk("post_rst_len", n, 4096);
        chk("post_rst_bad", bad, 0);
        tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
